// File: rtl/microc_ctrl_fsm_pkg.sv
// microc_ctrl_fsm_pkg -- shared constants and types for the microc controller.
//   State encoding (2-bit state register), opcode match patterns for the
//   decoder, and the strobe bundle passed from the decoder to the top.
package microc_ctrl_fsm_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_FETCH = 2'b01;
   localparam logic [1:0] ST_EXEC  = 2'b10;
   localparam logic [1:0] ST_HALT  = 2'b11;

   // '?' bits are don't-care when used as casez items
   localparam logic [5:0] OP_ALU = 6'b1?????;
   localparam logic [5:0] OP_NOP = 6'b000000;
   localparam logic [5:0] OP_LI  = 6'b0001??;
   localparam logic [5:0] OP_J   = 6'b010000;
   localparam logic [5:0] OP_JZ  = 6'b010001;
   localparam logic [5:0] OP_JNZ = 6'b010010;

   typedef struct packed {
      logic       pc_en;
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic       wez;
      logic [2:0] op;
   } strobes_t;

   // Quiescent strobe values: PC mux parked on PC+1, nothing written
   localparam strobes_t STROBES_IDLE = '{pc_en: 1'b0, s_inc: 1'b1, s_inm: 1'b0,
                                         we3: 1'b0, wez: 1'b0, op: 3'b000};

endpackage

// File: rtl/microc_ctrl_fsm_if.sv
// microc_ctrl_fsm_if -- datapath-facing bundle of the microc controller.
//   master : datapath side, drives run/opcode/z, observes the strobes
//   slave  : controller side, drives pc_en/s_inc/s_inm/we3/wez/Op/halted/icount
interface microc_ctrl_fsm_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [5:0]       opcode;
   logic             z;
   logic             pc_en;
   logic             s_inc;
   logic             s_inm;
   logic             we3;
   logic             wez;
   logic [2:0]       Op;
   logic             halted;
   logic [CNT_W-1:0] icount;

   modport master (
      output run, opcode, z,
      input  pc_en, s_inc, s_inm, we3, wez, Op, halted, icount
   );

   modport slave (
      input  run, opcode, z,
      output pc_en, s_inc, s_inm, we3, wez, Op, halted, icount
   );
endinterface

// File: rtl/microc_ctrl_fsm_decode.sv
// microc_decode -- combinational IR/z to datapath strobe decode.
//   exec_i    : 1 while the controller is in EXEC
//   ir_i      : latched instruction register
//   z_i       : live zero flag (conditional jumps look at it during EXEC)
//   strb_o    : strobe bundle (quiescent values outside EXEC)
//   illegal_o : undefined opcode in EXEC and HALT_ON_ILLEGAL set
module microc_decode
   import microc_ctrl_fsm_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       exec_i,
   input  logic [5:0] ir_i,
   input  logic       z_i,
   output strobes_t   strb_o,
   output logic       illegal_o
);

   always_comb begin
      strb_o    = STROBES_IDLE;
      illegal_o = 1'b0;
      if (exec_i) begin
         strb_o.pc_en = 1'b1;
         casez (ir_i)
            OP_ALU: begin
               strb_o.we3 = 1'b1;
               strb_o.wez = 1'b1;
               strb_o.op  = ir_i[4:2];
            end
            OP_NOP: ;
            OP_LI: begin
               strb_o.s_inm = 1'b1;
               strb_o.we3   = 1'b1;
            end
            OP_J:   strb_o.s_inc = 1'b0;
            OP_JZ:  strb_o.s_inc = ~z_i;
            OP_JNZ: strb_o.s_inc = z_i;
            default: begin
               // Undefined opcode: either freeze (and halt) or fall through as nop
               if (HALT_ON_ILLEGAL) begin
                  strb_o.pc_en = 1'b0;
                  illegal_o    = 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/microc_ctrl_fsm.sv
// microc_ctrl_fsm -- control FSM for the microc datapath.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave modport (run/opcode/z in; strobes, halted, icount out)
// Holds the state register, the instruction register and the
// retired-instruction counter; strobe decode lives in microc_decode.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | one-cycle settle after reset, then FETCH
//   FETCH | latch opcode into IR when run=1, else stall
//   EXEC  | drive strobes from IR, retire, back to FETCH
//   HALT  | undefined opcode seen; absorbing until reset
module microc_ctrl_fsm
   import microc_ctrl_fsm_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 16
) (
   input  logic              clk,
   input  logic              reset,
   microc_ctrl_fsm_if.slave  bus
);

   logic [1:0]       state_q, state_d;
   logic [5:0]       ir_q, ir_d;
   logic [CNT_W-1:0] icount_q, icount_d;
   strobes_t         strb;
   logic             illegal;

   microc_decode #(
      .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
   ) u_decode (
      .exec_i    (state_q == ST_EXEC),
      .ir_i      (ir_q),
      .z_i       (bus.z),
      .strb_o    (strb),
      .illegal_o (illegal)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (bus.run) begin
               ir_d    = bus.opcode;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC:  state_d = illegal ? ST_HALT : ST_FETCH;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // pc_en is only ever high in EXEC, so it doubles as the retire strobe
   assign icount_d = strb.pc_en ? icount_q + CNT_W'(1) : icount_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ir_q     <= '0;
         icount_q <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         icount_q <= icount_d;
      end
   end

   assign bus.pc_en  = strb.pc_en;
   assign bus.s_inc  = strb.s_inc;
   assign bus.s_inm  = strb.s_inm;
   assign bus.we3    = strb.we3;
   assign bus.wez    = strb.wez;
   assign bus.Op     = strb.op;
   assign bus.halted = (state_q == ST_HALT);
   assign bus.icount = icount_q;

endmodule

// File: tb/tb_microc_ctrl_fsm.sv
// Testbench for microc_ctrl_fsm: instance A uses the default parameters,
// instance B uses CNT_W=4 with undefined opcodes executed as nop.
module tb_microc_ctrl_fsm;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;

   always #5 clk = ~clk;

   microc_ctrl_fsm_if #(.CNT_W(16)) bus_a ();
   microc_ctrl_fsm_if #(.CNT_W(4))  bus_b ();

   microc_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(16)) dut_a (
      .clk   (clk),
      .reset (reset_a),
      .bus   (bus_a.slave)
   );

   microc_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (bus_b.slave)
   );

   typedef struct {
      string       name;
      logic        s_inc;
      logic        s_inm;
      logic        we3;
      logic        wez;
      logic [2:0]  op;
      logic [15:0] cnt;
   } exp_t;

   exp_t        qa[$];
   logic [3:0]  qb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] cnt_a = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor A: every retire (pc_en=1, sampled mid-cycle) is checked against the next expectation
   exp_t ea;
   always @(negedge clk) begin
      if (bus_a.pc_en === 1'b1) begin
         check("a_retire_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) begin
            ea = qa.pop_front();
            check({ea.name, "_s_inc"},  32'(bus_a.s_inc),  32'(ea.s_inc));
            check({ea.name, "_s_inm"},  32'(bus_a.s_inm),  32'(ea.s_inm));
            check({ea.name, "_we3"},    32'(bus_a.we3),    32'(ea.we3));
            check({ea.name, "_wez"},    32'(bus_a.wez),    32'(ea.wez));
            check({ea.name, "_Op"},     32'(bus_a.Op),     32'(ea.op));
            check({ea.name, "_icount"}, 32'(bus_a.icount), 32'(ea.cnt));
            check({ea.name, "_halted"}, 32'(bus_a.halted), 32'd0);
         end
      end
   end

   // Monitor B: icount seen at each retire
   logic [3:0] eb;
   always @(negedge clk) begin
      if (bus_b.pc_en === 1'b1) begin
         check("b_retire_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) begin
            eb = qb.pop_front();
            check("b_retire_icount", 32'(bus_b.icount), 32'(eb));
         end
      end
   end

   // Starts in FETCH, #1 after a rising edge; returns the same way after EXEC.
   // z is set opposite in FETCH and to zv only in EXEC, and the opcode input is
   // scrambled during EXEC, so the strobes must come from IR and live z.
   task automatic issue_a(input string name, input logic [5:0] op, input logic zv,
                          input logic e_inc, input logic e_inm, input logic e_we3,
                          input logic e_wez, input logic [2:0] e_op);
      exp_t e;
      e.name  = name;
      e.s_inc = e_inc;
      e.s_inm = e_inm;
      e.we3   = e_we3;
      e.wez   = e_wez;
      e.op    = e_op;
      e.cnt   = cnt_a;
      qa.push_back(e);
      bus_a.opcode = op;
      bus_a.z      = ~zv;
      @(posedge clk); #1;
      bus_a.z      = zv;
      bus_a.opcode = ~op;
      @(posedge clk); #1;
      cnt_a = cnt_a + 16'd1;
      check({name, "_icount_after"}, 32'(bus_a.icount), 32'(cnt_a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual t=%0t required <200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_a = 1'b0;
      reset_b = 1'b0;
      bus_a.run = 1'b1; bus_a.opcode = 6'b000100; bus_a.z = 1'b0;
      bus_b.run = 1'b1; bus_b.opcode = 6'b000000; bus_b.z = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_pc_en",  32'(bus_a.pc_en),  32'd0);
      check("rst_s_inc",  32'(bus_a.s_inc),  32'd1);
      check("rst_s_inm",  32'(bus_a.s_inm),  32'd0);
      check("rst_we3",    32'(bus_a.we3),    32'd0);
      check("rst_wez",    32'(bus_a.wez),    32'd0);
      check("rst_Op",     32'(bus_a.Op),     32'd0);
      check("rst_halted", 32'(bus_a.halted), 32'd0);
      check("rst_icount", 32'(bus_a.icount), 32'd0);
      check("b_rst_icount", 32'(bus_b.icount), 32'd0);

      // Release: edge 1 IDLE->FETCH, edge 2 latches li, cycle 3 is EXEC
      reset_a = 1'b1;
      @(posedge clk); #1;
      check("cycle2_fetch_pc_en", 32'(bus_a.pc_en), 32'd0);
      issue_a("li_first", 6'b000100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);

      //       name        opcode     z     inc   inm   we3   wez   Op
      issue_a("alu_110100", 6'b110100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101);
      issue_a("jz_z1",      6'b010001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("jz_z0",      6'b010001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("jnz_z1",     6'b010010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("jnz_z0",     6'b010010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("j",          6'b010000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("nop",        6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      issue_a("li_000111",  6'b000111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
      issue_a("alu_111111", 6'b111111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111);
      issue_a("alu_100000", 6'b100000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);

      // Stall in FETCH for 5 cycles
      bus_a.run    = 1'b0;
      bus_a.opcode = 6'b101000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_pc_en",  32'(bus_a.pc_en),  32'd0);
         check("stall_icount", 32'(bus_a.icount), 32'(cnt_a));
      end
      begin
         exp_t e;
         e.name = "alu_after_stall"; e.s_inc = 1'b1; e.s_inm = 1'b0;
         e.we3 = 1'b1; e.wez = 1'b1; e.op = 3'b010; e.cnt = cnt_a;
         qa.push_back(e);
      end
      bus_a.run = 1'b1;
      @(posedge clk); #1;
      check("exec_after_run_pc_en", 32'(bus_a.pc_en), 32'd1);
      @(posedge clk); #1;
      cnt_a = cnt_a + 16'd1;
      check("after_stall_icount", 32'(bus_a.icount), 32'(cnt_a));

      // Undefined opcode halts
      bus_a.opcode = 6'b011111;
      @(posedge clk); #1;
      check("ill_exec_pc_en",  32'(bus_a.pc_en),  32'd0);
      check("ill_exec_we3",    32'(bus_a.we3),    32'd0);
      check("ill_exec_wez",    32'(bus_a.wez),    32'd0);
      check("ill_exec_s_inm",  32'(bus_a.s_inm),  32'd0);
      check("ill_exec_halted", 32'(bus_a.halted), 32'd0);
      @(posedge clk); #1;
      check("ill_halted", 32'(bus_a.halted), 32'd1);
      for (int i = 0; i < 4; i++) begin
         bus_a.run    = i[0];
         bus_a.opcode = 6'b000100;
         @(posedge clk); #1;
         check("halt_stays",  32'(bus_a.halted), 32'd1);
         check("halt_pc_en",  32'(bus_a.pc_en),  32'd0);
         check("halt_icount", 32'(bus_a.icount), 32'(cnt_a));
      end

      // Asynchronous reset out of HALT
      #2;
      reset_a = 1'b0;
      #1;
      check("rst_from_halt_halted", 32'(bus_a.halted), 32'd0);
      check("rst_from_halt_icount", 32'(bus_a.icount), 32'd0);
      cnt_a = '0;
      @(posedge clk); #1;
      bus_a.run = 1'b1;
      reset_a   = 1'b1;
      @(posedge clk); #1;
      issue_a("li_after_reset", 6'b000100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);

      // Reset mid-EXEC of an ALU op, between clock edges
      bus_a.opcode = 6'b110100;
      @(posedge clk); #1;
      check("midexec_we3_before",    32'(bus_a.we3),    32'd1);
      check("midexec_icount_before", 32'(bus_a.icount), 32'd1);
      #1;
      reset_a = 1'b0;
      #1;
      check("midexec_we3",    32'(bus_a.we3),    32'd0);
      check("midexec_wez",    32'(bus_a.wez),    32'd0);
      check("midexec_pc_en",  32'(bus_a.pc_en),  32'd0);
      check("midexec_s_inc",  32'(bus_a.s_inc),  32'd1);
      check("midexec_Op",     32'(bus_a.Op),     32'd0);
      check("midexec_icount", 32'(bus_a.icount), 32'd0);

      // Instance B: 16 nops wrap a 4-bit counter, undefined opcode runs as nop
      @(posedge clk); #1;
      reset_b = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         qb.push_back(4'(i));
         @(posedge clk);
         @(posedge clk);
      end
      #1;
      check("b_wrap_icount", 32'(bus_b.icount), 32'd0);
      bus_b.opcode = 6'b011111;
      qb.push_back(4'd0);
      @(posedge clk); #1;
      check("b_ill_pc_en",  32'(bus_b.pc_en),  32'd1);
      check("b_ill_halted", 32'(bus_b.halted), 32'd0);
      bus_b.run = 1'b0;
      @(posedge clk); #1;
      check("b_ill_after_halted", 32'(bus_b.halted), 32'd0);
      check("b_ill_after_icount", 32'(bus_b.icount), 32'd1);
      @(posedge clk); #1;

      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/microc_ctrl_fsm.md
MICROC_CTRL_FSM -- requirements
Module: microc_ctrl_fsm

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1, meaning: an undefined opcode sends the FSM to HALT (1) or is executed as nop (0).
REQ-002 Parameter CNT_W, default 16, meaning: width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 run  input  1  fetch enable; 0 stalls in FETCH.
REQ-006 opcode  input  6  instruction opcode from the microc datapath.
REQ-007 z  input  1  zero flag from the microc datapath.
REQ-008 pc_en  output  1  PC register load enable.
REQ-009 s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target.
REQ-010 s_inm  output  1  register-file write-data select: 1 = immediate.
REQ-011 we3  output  1  register-file write enable.
REQ-012 wez  output  1  zero-flag write enable.
REQ-013 Op  output  3  ALU operation select.
REQ-014 halted  output  1  1 while in HALT.
REQ-015 icount  output  CNT_W  retired-instruction count.

Function
REQ-016 States: IDLE, FETCH, EXEC, HALT; state register 2 bits.
REQ-017 IDLE -> FETCH unconditionally after one cycle.
REQ-018 FETCH: when run=1, latch opcode into an internal 6-bit IR and go to EXEC; when run=0, stay in FETCH with IR unchanged.
REQ-019 EXEC -> FETCH after one cycle for defined opcodes; EXEC -> HALT for undefined opcodes when HALT_ON_ILLEGAL=1.
REQ-020 HALT is absorbing; exits only via reset.
REQ-021 Outside EXEC: pc_en, we3, wez, s_inm = 0; s_inc = 1; Op = 000.
REQ-022 Outputs are combinational from state and IR only; the opcode input does not affect outputs directly.
REQ-023 EXEC with IR=1xxxxx (ALU): pc_en=1, s_inc=1, we3=1, wez=1, s_inm=0, Op=IR[4:2].
REQ-024 EXEC with IR=000000 (nop): pc_en=1, s_inc=1, all other strobes 0.
REQ-025 EXEC with IR=0001xx (li): pc_en=1, s_inc=1, s_inm=1, we3=1, wez=0.
REQ-026 EXEC with IR=010000 (j): pc_en=1, s_inc=0, we3=0, wez=0.
REQ-027 EXEC with IR=010001 (jz): pc_en=1, s_inc=~z, we3=0, wez=0; z is sampled live during EXEC.
REQ-028 EXEC with IR=010010 (jnz): pc_en=1, s_inc=z, we3=0, wez=0.
REQ-029 Undefined opcode in EXEC: all strobes 0 and pc_en=0 if HALT_ON_ILLEGAL=1; nop behaviour otherwise.
REQ-030 Each defined instruction takes exactly 2 cycles (FETCH+EXEC) when run=1.
REQ-031 icount increments by 1 on every EXEC cycle with pc_en=1.
REQ-032 icount wraps from all-ones to 0.
REQ-033 run is ignored in EXEC and HALT.

Reset
REQ-034 Reset assertion, even mid-EXEC, immediately forces: state=IDLE, IR=000000, icount=0, halted=0, pc_en=we3=wez=s_inm=0, s_inc=1, Op=000.
REQ-035 After reset deassertion, the first FETCH occurs on the second rising edge.

Structure
REQ-036 A shared package holds the state encoding constants (IDLE=00, FETCH=01, EXEC=10, HALT=11) and the opcode pattern constants.
REQ-037 A single sub-module, microc_decode, performs the combinational IR/z-to-strobe decode; the top holds the FSM, IR, and counter.

Verification
REQ-038 Release reset with run=1 and opcode=000100 (li) -> cycle 2 FETCH, cycle 3 EXEC with s_inm=1, we3=1, pc_en=1; icount=1 afterwards.
REQ-039 Opcode=110100 (ALU) -> in EXEC: Op=101, we3=1, wez=1, s_inc=1.
REQ-040 jz with z=1 -> s_inc=0; jz with z=0 -> s_inc=1; jnz gives the inverse; pc_en=1 in all cases.
REQ-041 Hold run=0 for 5 cycles in FETCH -> pc_en=0 throughout and icount unchanged; raise run -> EXEC on the next edge.
REQ-042 Opcode=011111 with HALT_ON_ILLEGAL=1 -> halted=1 from the cycle after EXEC, strobes 0, and it stays halted until reset=0.
REQ-043 Assert reset mid-EXEC of an ALU op -> we3 and wez drop to 0 without waiting for a clock edge, icount=0; with CNT_W=4, 16 nops wrap icount to 0.
